scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 137 +++++++++++++
 tb/tb_scan_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// Row driver with two behaviours selected by i_mode:
//   - direct decode: the row named by i_in is driven one-hot on the next edge;
//   - autonomous scan: rows 0..LAST are driven in turn, each for DWELL cycles,
//     wrapping back to row 0 with a one-cycle o_wrap pulse.
// i_ena low blanks the row drive without losing the scan position.
//
// Parameters
//   N      select width (1..6); o_out is 2**N bits wide
//   DWELL  cycles each row is held while scanning (>= 1)
//   LAST   highest row index visited while scanning (0..2**N-1)
//
// Ports
//   i_clk    clock, all state updates on its rising edge
//   i_rst    synchronous active-high reset
//   i_ena    enable; 0 forces o_out to all-zero
//   i_mode   0 = direct decode of i_in, 1 = autonomous row scan
//   i_in     row select used in direct mode
//   o_out    registered one-hot row drive, or all-zero
//   o_index  registered current row index
//   o_wrap   registered one-cycle pulse when the scan wraps to row 0
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int LAST  = (2 ** N) - 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_mode,
  input  logic [N-1:0]     i_in,
  output logic [2**N-1:0]  o_out,
  output logic [N-1:0]     o_index,
  output logic             o_wrap
);

  localparam int W  = 2 ** N;
  // Dwell counter only needs to reach DWELL-1; keep at least one bit so the
  // DWELL=1 case still has a legal (always-zero) counter.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL - 1);
  localparam logic [CW-1:0] DWELL_ONE = CW'(1);
  localparam logic [N-1:0]  LAST_IDX  = N'(LAST);
  localparam logic [N-1:0]  IDX_ONE   = N'(1);

  // One-hot encode of a row index.
  function automatic logic [W-1:0] f_onehot(input logic [N-1:0] i_idx);
    logic [W-1:0] v_hot;
    v_hot        = '0;
    v_hot[i_idx] = 1'b1;
    return v_hot;
  endfunction

  logic [W-1:0]  r_out;
  logic [N-1:0]  r_index;
  logic [CW-1:0] r_dwell;
  logic          r_wrap;

  logic [W-1:0]  w_out_nxt;
  logic [N-1:0]  w_index_nxt;
  logic [CW-1:0] w_dwell_nxt;
  logic          w_wrap_nxt;
  logic          w_active;
  logic          w_at_last;
  logic [N-1:0]  w_next_row;

  // Scan position helpers: a row drive is "active" when any bit is set, and
  // any index at or beyond LAST (e.g. loaded directly) wraps to row 0.
  always_comb begin
    w_active   = (r_out != '0);
    w_at_last  = (r_index >= LAST_IDX);
    if (w_at_last) begin
      w_next_row = '0;
    end else begin
      w_next_row = r_index + IDX_ONE;
    end
  end

  // Next-state selection for the row drive, index, dwell counter and wrap.
  always_comb begin
    w_out_nxt   = r_out;
    w_index_nxt = r_index;
    w_dwell_nxt = r_dwell;
    w_wrap_nxt  = 1'b0;

    if (!i_mode) begin
      // Direct decode: index follows i_in even when blanked, so a later
      // switch to scan mode resumes from the loaded row.
      w_index_nxt = i_in;
      w_dwell_nxt = '0;
      if (i_ena) begin
        w_out_nxt = f_onehot(i_in);
      end else begin
        w_out_nxt = '0;
      end
    end else if (!i_ena) begin
      // Paused scan: keep position, blank the drive.
      w_out_nxt = '0;
    end else if (!w_active) begin
      // Scan (re)start: drive the held row for a fresh full dwell.
      w_out_nxt   = f_onehot(r_index);
      w_dwell_nxt = '0;
    end else if (r_dwell != DWELL_MAX) begin
      w_dwell_nxt = r_dwell + DWELL_ONE;
    end else begin
      // Dwell complete: move to the next row, pulsing wrap on return to 0.
      w_dwell_nxt = '0;
      w_index_nxt = w_next_row;
      w_out_nxt   = f_onehot(w_next_row);
      w_wrap_nxt  = w_at_last;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out   <= '0;
      r_index <= '0;
      r_dwell <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_index <= w_index_nxt;
      r_dwell <= w_dwell_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign o_out   = r_out;
  assign o_index = r_index;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//
// Three scan_decoder instances (N=3) with different DWELL/LAST settings are
// driven one at a time with directed vectors. Each stimulus step pushes the
// expected post-edge outputs into a scoreboard queue; a monitor pops one
// entry after each rising edge and compares it with the addressed instance.
//   dut 0: DWELL=4, LAST=7   dut 1: DWELL=1, LAST=5   dut 2: DWELL=4, LAST=5
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  typedef struct {
    int         dut;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
    string      nm;
  } exp_t;

  logic       clk;
  logic       rst_s  [3];
  logic       ena_s  [3];
  logic       mode_s [3];
  logic [2:0] in_s   [3];
  logic [7:0] out_s  [3];
  logic [2:0] idx_s  [3];
  logic       wrap_s [3];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  scan_decoder #(.N(3), .DWELL(4), .LAST(7)) u_dut0 (
    .i_clk(clk), .i_rst(rst_s[0]), .i_ena(ena_s[0]), .i_mode(mode_s[0]),
    .i_in(in_s[0]), .o_out(out_s[0]), .o_index(idx_s[0]), .o_wrap(wrap_s[0])
  );

  scan_decoder #(.N(3), .DWELL(1), .LAST(5)) u_dut1 (
    .i_clk(clk), .i_rst(rst_s[1]), .i_ena(ena_s[1]), .i_mode(mode_s[1]),
    .i_in(in_s[1]), .o_out(out_s[1]), .o_index(idx_s[1]), .o_wrap(wrap_s[1])
  );

  scan_decoder #(.N(3), .DWELL(4), .LAST(5)) u_dut2 (
    .i_clk(clk), .i_rst(rst_s[2]), .i_ena(ena_s[2]), .i_mode(mode_s[2]),
    .i_in(in_s[2]), .o_out(out_s[2]), .o_index(idx_s[2]), .o_wrap(wrap_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs to dut d and record what it must show after
  // the following rising edge.
  task automatic step(input int d, input logic r, input logic e, input logic m,
                      input logic [2:0] i, input logic [7:0] eo,
                      input logic [2:0] ei, input logic ew, input string nm);
    exp_t x;
    @(negedge clk);
    rst_s[d]  = r;
    ena_s[d]  = e;
    mode_s[d] = m;
    in_s[d]   = i;
    x.dut = d; x.out = eo; x.idx = ei; x.wrap = ew; x.nm = nm;
    sb.push_back(x);
  endtask

  // Monitor: one scoreboard entry is due per rising edge after it was pushed.
  always @(posedge clk) begin
    exp_t e_v;
    #1;
    if (sb.size() > 0) begin
      e_v = sb.pop_front();
      checks++;
      if (out_s[e_v.dut] !== e_v.out || idx_s[e_v.dut] !== e_v.idx ||
          wrap_s[e_v.dut] !== e_v.wrap) begin
        errors++;
        $display("FAIL %s dut%0d @%0t: got out=%h index=%0d wrap=%b, expected out=%h index=%0d wrap=%b",
                 e_v.nm, e_v.dut, $time, out_s[e_v.dut], idx_s[e_v.dut],
                 wrap_s[e_v.dut], e_v.out, e_v.idx, e_v.wrap);
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1; ena_s[d] = 1'b0; mode_s[d] = 1'b0; in_s[d] = 3'd0;
    end

    // ---------------- dut 0: DWELL=4, LAST=7 ----------------
    step(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, "reset");
    // Full scan from reset: every row for 4 cycles, then wrap.
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 4; k++)
        step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01 << r, 3'(r), 1'b0, "scan_row");
    step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1, "scan_wrap");
    for (int k = 0; k < 3; k++)
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0, "scan_after_wrap");
    for (int r = 1; r < 6; r++)
      for (int k = 0; k < 4; k++)
        step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01 << r, 3'(r), 1'b0, "scan_row2");
    for (int k = 0; k < 2; k++)
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h40, 3'd6, 1'b0, "scan_row6");
    // Reset during active scan at index 6, with other inputs asserted.
    for (int k = 0; k < 2; k++)
      step(0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h00, 3'd0, 1'b0, "reset_mid_scan");
    // Direct decode then blank.
    step(0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0, "direct");
    step(0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 3'd5, 1'b0, "direct_ena_off");
    step(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, "reset2");
    // Pause mid-row: row 2 shown 2 cycles, paused 3, then a full 4 again.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01 << r, 3'(r), 1'b0, "pause_lead");
    for (int k = 0; k < 2; k++)
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h04, 3'd2, 1'b0, "pause_row2");
    for (int k = 0; k < 3; k++)
      step(0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 3'd2, 1'b0, "paused");
    for (int k = 0; k < 4; k++)
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h04, 3'd2, 1'b0, "resume_row2");
    step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h08, 3'd3, 1'b0, "resume_row3");
    // 1->0 mid-dwell: direct takes over at once; 0->1 continues from row 1.
    step(0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h02, 3'd1, 1'b0, "scan_to_direct");
    for (int k = 0; k < 3; k++)
      step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h02, 3'd1, 1'b0, "direct_to_scan");
    step(0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h04, 3'd2, 1'b0, "direct_to_scan_adv");

    // ---------------- dut 1: DWELL=1, LAST=5 ----------------
    step(1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, "reset_d1");
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 6; r++)
        step(1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01 << r, 3'(r),
             (p > 0 && r == 0) ? 1'b1 : 1'b0, "partial_scan");
    step(1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1, "partial_wrap");
    step(1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h02, 3'd1, 1'b0, "partial_after_wrap");

    // ---------------- dut 2: DWELL=4, LAST=5 ----------------
    step(2, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, "reset_d2");
    step(2, 1'b0, 1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b0, "handoff_direct");
    for (int k = 0; k < 3; k++)
      step(2, 1'b0, 1'b1, 1'b1, 3'd0, 8'h80, 3'd7, 1'b0, "handoff_hold");
    step(2, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1, "handoff_wrap");
    for (int k = 0; k < 3; k++)
      step(2, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0, "handoff_row0");
    step(2, 1'b0, 1'b1, 1'b1, 3'd0, 8'h02, 3'd1, 1'b0, "handoff_row1");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
